// File: rtl/pwm_cfg_ctrl.sv
// Wishbone configuration slave for the multi-channel PWM core: shadow period/duty
// registers, per-channel enables, commit-at-wrap of shadow values and a wrap interrupt.
module pwm_cfg_ctrl #(
  parameter int          NCH      = 4,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [NCH-1:0]       period_wrap_i,
  output logic [NCH-1:0]       ch_en_o,
  output logic [NCH*CNT_W-1:0] ch_period_o,
  output logic [NCH*CNT_W-1:0] ch_duty_o,
  output logic [NCH-1:0]       ch_oeb_o,
  output logic                 irq_o
);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   r_irq_en;
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_sticky;
  logic [NCH-1:0]   r_oeb;
  logic             r_irq;
  logic [CNT_W-1:0] r_per_sh  [NCH];
  logic [CNT_W-1:0] r_duty_sh [NCH];
  logic [CNT_W-1:0] r_per     [NCH];
  logic [CNT_W-1:0] r_duty    [NCH];

  logic             w_req;
  logic             w_hit;
  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_stat_wr;
  logic [7:0]       w_off;
  logic [31:0]      w_mask32;
  logic [CNT_W-1:0] w_mask;
  logic [NCH-1:0]   w_per_hit;
  logic [NCH-1:0]   w_duty_hit;
  logic [NCH-1:0]   w_per_wr;
  logic [NCH-1:0]   w_duty_wr;
  logic [NCH-1:0]   w_set;
  logic [NCH-1:0]   w_w1c;
  logic [NCH-1:0]   w_pend_eff;
  logic [NCH-1:0]   w_commit;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Address decode, byte-lane mask and per-channel commit condition.
  always_comb begin
    w_off      = wbs_adr_i[7:0];
    w_hit      = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    w_req      = wbs_stb_i & wbs_cyc_i & ~r_ack;
    w_wr       = w_req & wbs_we_i & w_hit;
    w_ctrl_wr  = w_wr & (w_off == 8'h00);
    w_stat_wr  = w_wr & (w_off == 8'h04);
    w_mask32   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    w_mask     = w_mask32[CNT_W-1:0];
    w_per_hit  = '0;
    w_duty_hit = '0;
    w_per_wr   = '0;
    w_duty_wr  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_per_hit[i]  = w_hit & (w_off == 8'(16 + 8 * i));
      w_duty_hit[i] = w_hit & (w_off == 8'(20 + 8 * i));
      w_per_wr[i]   = w_wr & w_per_hit[i];
      w_duty_wr[i]  = w_wr & w_duty_hit[i];
    end
    w_set      = (w_ctrl_wr & wbs_sel_i[1]) ? wbs_dat_i[8 +: NCH]  : '0;
    w_w1c      = (w_stat_wr & wbs_sel_i[2]) ? wbs_dat_i[16 +: NCH] : '0;
    // A set arriving with the wrap commits on the same edge instead of waiting a period.
    w_pend_eff = r_pend | w_set;
    w_commit   = w_pend_eff & (period_wrap_i | ~r_en);
  end

  // Read-data multiplexer; unmapped offsets and foreign bases read zero.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_hit && (w_off == 8'h00)) begin
      w_rdata[NCH-1:0]   = r_en;
      w_rdata[16 +: NCH] = r_irq_en;
    end else if (w_hit && (w_off == 8'h04)) begin
      w_rdata[NCH-1:0]   = r_pend;
      w_rdata[16 +: NCH] = r_sticky;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        w_rdata[CNT_W-1:0] = w_rdata[CNT_W-1:0]
                           | (w_per_hit[i]  ? r_per_sh[i]  : {CNT_W{1'b0}})
                           | (w_duty_hit[i] ? r_duty_sh[i] : {CNT_W{1'b0}});
      end
    end
  end

  // Bus handshake: one-cycle ack, read data registered alongside it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0000_0000;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wbs_we_i) ? w_rdata : 32'h0000_0000;
    end
  end

  // Control, status, shadow and active channel registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_en     <= {NCH{1'b0}};
      r_irq_en <= {NCH{1'b0}};
      r_pend   <= {NCH{1'b0}};
      r_sticky <= {NCH{1'b0}};
      r_oeb    <= {NCH{1'b1}};
      r_irq    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_per_sh[i]  <= {CNT_W{1'b0}};
        r_duty_sh[i] <= {CNT_W{1'b0}};
        r_per[i]     <= {CNT_W{1'b0}};
        r_duty[i]    <= {CNT_W{1'b0}};
      end
    end else begin
      if (w_ctrl_wr && wbs_sel_i[0]) r_en     <= wbs_dat_i[NCH-1:0];
      if (w_ctrl_wr && wbs_sel_i[2]) r_irq_en <= wbs_dat_i[16 +: NCH];
      r_pend   <= w_pend_eff & ~w_commit;
      r_sticky <= (r_sticky & ~w_w1c) | (period_wrap_i & r_en);
      r_oeb    <= ~r_en;
      r_irq    <= |(r_sticky & r_irq_en);
      for (int i = 0; i < NCH; i++) begin
        if (w_per_wr[i])
          r_per_sh[i]  <= (r_per_sh[i] & ~w_mask) | (wbs_dat_i[CNT_W-1:0] & w_mask);
        if (w_duty_wr[i])
          r_duty_sh[i] <= (r_duty_sh[i] & ~w_mask) | (wbs_dat_i[CNT_W-1:0] & w_mask);
        // Commit samples the shadow before any same-cycle write lands.
        if (w_commit[i]) begin
          r_per[i]  <= r_per_sh[i];
          r_duty[i] <= (r_duty_sh[i] > r_per_sh[i]) ? r_per_sh[i] : r_duty_sh[i];
        end
      end
    end
  end

  // Pack the active per-channel registers onto the flat output buses.
  always_comb begin
    ch_period_o = '0;
    ch_duty_o   = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_period_o[i*CNT_W +: CNT_W] = r_per[i];
      ch_duty_o[i*CNT_W +: CNT_W]   = r_duty[i];
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign ch_en_o   = r_en;
  assign ch_oeb_o  = r_oeb;
  assign irq_o     = r_irq;
  assign w_unused  = ^{wbs_dat_i, w_mask32};

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Directed bench for pwm_cfg_ctrl: stimulus pushes expectations into queues,
// a negedge monitor pops and compares read data and output probes.
module tb_pwm_cfg_ctrl;

  localparam logic [31:0] B = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [3:0]  wrap;
  logic [3:0]  en;
  logic [63:0] per;
  logic [63:0] duty;
  logic [3:0]  oeb;
  logic        irq;

  pwm_cfg_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .period_wrap_i(wrap),
    .ch_en_o(en), .ch_period_o(per), .ch_duty_o(duty), .ch_oeb_o(oeb), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sig;
    int          ch;
    logic [31:0] exp;
  } probe_t;

  logic [31:0] rd_q[$];
  probe_t      probe_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          timeouts = 0;
  logic        done = 1'b0;
  logic        fin = 1'b0;
  logic [31:0] m_exp;
  logic [31:0] m_act;
  probe_t      m_p;

  function automatic logic [31:0] sig_val(input int sig, input int ch);
    case (sig)
      0:       return {16'h0, per[ch*16 +: 16]};
      1:       return {16'h0, duty[ch*16 +: 16]};
      2:       return {28'h0, en};
      3:       return {28'h0, oeb};
      4:       return {31'h0, irq};
      5:       return {31'h0, ack};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      0:       return "period";
      1:       return "duty";
      2:       return "ch_en";
      3:       return "oeb";
      4:       return "irq";
      5:       return "ack";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: read acks against the read queue, then drain pending probes.
  always @(negedge clk) begin
    if (ack && !we) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_ack: unexpected read ack, got data %h, required no ack", dat_o);
      end else begin
        m_exp = rd_q.pop_front();
        if (dat_o !== m_exp) begin
          n_errors++;
          $display("FAIL rd_data @%0t: got %h, required %h", $time, dat_o, m_exp);
        end
      end
    end
    while (probe_q.size() > 0) begin
      m_p = probe_q.pop_front();
      m_act = sig_val(m_p.sig, m_p.ch);
      n_checks++;
      if (m_act !== m_p.exp) begin
        n_errors++;
        $display("FAIL %s[%0d] @%0t: got %h, required %h", sig_name(m_p.sig), m_p.ch, $time, m_act, m_p.exp);
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      n_checks++;
      if (rd_q.size() != 0 || timeouts != 0) begin
        n_errors++;
        $display("FAIL bus_done: got %0d reads unacked and %0d timeouts, required 0 and 0", rd_q.size(), timeouts);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic probe(input int sig, input int ch, input logic [31:0] exp);
    probe_q.push_back('{sig, ch, exp});
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [3:0] wrap_with);
    logic got;
    got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d; wrap = wrap_with;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      wrap = 4'h0;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0;
    if (!got) timeouts++;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(1'b1, a, s, d, 4'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus(1'b0, a, 4'hF, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    dat_i = 32'h0; adr = 32'h0; wrap = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Reset state
    probe(3, 0, 32'hF); probe(2, 0, 32'h0); probe(5, 0, 32'h0); probe(4, 0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      probe(0, c, 32'h0); probe(1, c, 32'h0);
    end
    tick();
    rd(B + 32'h04, 32'h0);

    // Ch0 disabled: set commits right away
    wr(B + 32'h10, 32'd100, 4'hF);
    wr(B + 32'h14, 32'd25, 4'hF);
    wr(B + 32'h00, 32'h0000_0100, 4'b0010);
    probe(0, 0, 32'd100); probe(1, 0, 32'd25);
    rd(B + 32'h04, 32'h0);

    // Ch1: establish period 50 / duty 20, enable, then stage duty 10
    wr(B + 32'h18, 32'd50, 4'hF);
    wr(B + 32'h1C, 32'd20, 4'hF);
    wr(B + 32'h00, 32'h0000_0200, 4'b0010);
    probe(0, 1, 32'd50); probe(1, 1, 32'd20);
    wr(B + 32'h00, 32'h0000_0002, 4'b0001);
    probe(2, 0, 32'h2); probe(3, 0, 32'hD);
    wr(B + 32'h1C, 32'd10, 4'hF);
    probe(1, 1, 32'd20);
    wr(B + 32'h00, 32'h0000_0200, 4'b0010);
    rd(B + 32'h04, 32'h0000_0002);
    probe(1, 1, 32'd20);
    tick();
    wrap = 4'b0010;
    probe(1, 1, 32'd20);
    tick();
    wrap = 4'h0;
    probe(1, 1, 32'd10); probe(0, 1, 32'd50);
    tick();
    rd(B + 32'h04, 32'h0002_0000);

    // Ch2: commit request on the same edge as wrap2
    wr(B + 32'h20, 32'd40, 4'hF);
    wr(B + 32'h24, 32'd8, 4'hF);
    wr(B + 32'h00, 32'h0000_0400, 4'b0010);
    wr(B + 32'h00, 32'h0000_0006, 4'b0001);
    wr(B + 32'h24, 32'd16, 4'hF);
    probe(1, 2, 32'd8);
    bus(1'b1, B + 32'h00, 4'b0010, 32'h0000_0400, 4'b0100);
    probe(1, 2, 32'd16); probe(0, 2, 32'd40);
    rd(B + 32'h04, 32'h0006_0000);

    // Ch3: duty above period clamps; byte-lane write leaves active alone
    wr(B + 32'h2C, 32'd300, 4'hF);
    wr(B + 32'h28, 32'd200, 4'hF);
    wr(B + 32'h00, 32'h0000_0800, 4'b0010);
    probe(0, 3, 32'd200); probe(1, 3, 32'd200);
    wr(B + 32'h28, 32'h0000_AB77, 4'b0010);
    rd(B + 32'h28, 32'h0000_ABC8);
    probe(0, 3, 32'd200);

    // Unmapped offsets and foreign base
    rd(B + 32'hFC, 32'h0);
    rd(32'h3000_0110, 32'h0);
    wr(32'h3000_0110, 32'h0000_1234, 4'hF);
    rd(B + 32'h10, 32'd100);
    rd(B + 32'h00, 32'h0000_0006);

    // Sticky: set beats W1C, plain W1C, W1C masked by sel
    bus(1'b1, B + 32'h04, 4'b0100, 32'h0002_0000, 4'b0010);
    rd(B + 32'h04, 32'h0006_0000);
    wr(B + 32'h04, 32'h0004_0000, 4'b0100);
    rd(B + 32'h04, 32'h0002_0000);
    wr(B + 32'h04, 32'h0002_0000, 4'b1011);
    rd(B + 32'h04, 32'h0002_0000);

    // Interrupt on ch0 wrap, cleared through W1C
    wr(B + 32'h00, 32'h0001_0007, 4'b0101);
    probe(4, 0, 32'h0); probe(3, 0, 32'h8);
    wrap = 4'b0001;
    tick();
    wrap = 4'h0;
    probe(4, 0, 32'h0);
    tick();
    probe(4, 0, 32'h1);
    tick();
    rd(B + 32'h00, 32'h0001_0007);
    wr(B + 32'h04, 32'h0001_0000, 4'b0100);
    probe(4, 0, 32'h0);
    rd(B + 32'h04, 32'h0002_0000);

    // Held strobe: ack 1,0,1,0
    rd_q.push_back(32'h0002_0000);
    rd_q.push_back(32'h0002_0000);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = B + 32'h04; sel = 4'hF;
    tick(); probe(5, 0, 32'h1);
    tick(); probe(5, 0, 32'h0);
    tick(); probe(5, 0, 32'h1);
    tick(); probe(5, 0, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    tick();

    // Reset in the middle of a read: no ack, state cleared
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = B + 32'h00; sel = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    probe(5, 0, 32'h0);
    tick();
    probe(5, 0, 32'h0);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    tick();
    probe(2, 0, 32'h0); probe(3, 0, 32'hF); probe(0, 0, 32'h0);
    probe(1, 3, 32'h0); probe(4, 0, 32'h0); probe(5, 0, 32'h0);
    tick();
    rd(B + 32'h04, 32'h0);
    rd(B + 32'h10, 32'h0);
    tick();
    done = 1'b1;
  end

endmodule
